bus_arbiter2: RTL and testbench

Two-master, one-slave arbiter for the core's peripheral request/response bus. It shares a single slave port, such as the CLINT or the peripheral decoder in front of it, between the instruction-fetch master (m0) and the data master (m1). Arbitration is round-robin and at most one transaction is outstanding at a time. A response timeout turns a missing slave response into an error response. The CLINT silently drops accesses to unmapped addresses and unsupported strobes, and this timeout is what keeps a master from hanging on them.

---
 rtl/bus_arbiter2.sv | 133 +++++++++++++
 tb/tb_bus_arbiter2.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter2.sv
// Two-master, one-slave round-robin bus arbiter with one outstanding
// transaction and a response timeout that turns a silent slave into an
// error response back to the requesting master.
module bus_arbiter2 #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       m_req_valid_i,
   input  logic [1:0][31:0] m_req_addr_i,
   input  logic [1:0][31:0] m_req_value_i,
   input  logic [1:0][3:0]  m_req_wstrb_i,
   output logic [1:0]       m_req_ready_o,
   output logic [1:0]       m_resp_valid_o,
   output logic [31:0]      m_resp_value_o,
   output logic             m_resp_err_o,
   output logic             s_req_valid_o,
   output logic [31:0]      s_req_addr_o,
   output logic [31:0]      s_req_value_o,
   output logic [3:0]       s_req_wstrb_o,
   input  logic             s_req_ready_i,
   input  logic             s_resp_valid_i,
   input  logic [31:0]      s_resp_value_i,
   output logic             busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic        last_q;
   logic        grant_q;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, value_q;
   logic [3:0]  wstrb_q;

   logic        sel;
   logic        accept;
   logic        timed_out;
   logic        resp_done;

   // Round-robin pick: a lone requester wins, a tie goes to the master not served last
   always_comb begin
      sel = m_req_valid_i[1];
      if (m_req_valid_i == 2'b11) begin
         sel = ~last_q;
      end
   end

   assign accept    = (state_q == S_IDLE) && (m_req_valid_i != 2'b00);
   // A real response in the timeout cycle takes priority over the error
   assign timed_out = (state_q == S_WAIT) && !s_resp_valid_i && (cnt_q == TIMEOUT_CNT);
   assign resp_done = (state_q == S_WAIT) && (s_resp_valid_i || (cnt_q == TIMEOUT_CNT));

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept)        state_d = S_REQ;
         S_REQ:  if (s_req_ready_i) state_d = S_WAIT;
         S_WAIT: if (resp_done)     state_d = S_IDLE;
         default:                   state_d = S_IDLE;
      endcase
   end

   // Wait counter: cleared on entry to WAIT, saturating so it can never wrap
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_REQ) begin
         cnt_d = 8'd0;
      end else if ((state_q == S_WAIT) && !resp_done && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Datapath registers: latched request, grant, round-robin history, counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q  <= 1'b1;
         grant_q <= 1'b0;
         cnt_q   <= 8'd0;
         addr_q  <= 32'd0;
         value_q <= 32'd0;
         wstrb_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
         if (accept) begin
            grant_q <= sel;
            addr_q  <= m_req_addr_i[sel];
            value_q <= m_req_value_i[sel];
            wstrb_q <= m_req_wstrb_i[sel];
         end
         if (resp_done) begin
            last_q <= grant_q;
         end
      end
   end

   // Output logic: ready is combinational from valid, responses are forwarded in-cycle
   always_comb begin
      m_req_ready_o  = 2'b00;
      m_resp_valid_o = 2'b00;
      m_resp_value_o = 32'd0;
      m_resp_err_o   = 1'b0;
      if (accept) begin
         m_req_ready_o[sel] = 1'b1;
      end
      if (resp_done) begin
         m_resp_valid_o[grant_q] = 1'b1;
         m_resp_err_o            = timed_out;
         if (s_resp_valid_i) begin
            m_resp_value_o = s_resp_value_i;
         end
      end
   end

   assign s_req_valid_o = (state_q == S_REQ);
   assign s_req_addr_o  = addr_q;
   assign s_req_value_o = value_q;
   assign s_req_wstrb_o = wstrb_q;
   assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: directed test-plan steps followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_bus_arbiter2;

   localparam int TIMEOUT = 16;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [1:0]       m_req_valid_i;
   logic [1:0][31:0] m_req_addr_i;
   logic [1:0][31:0] m_req_value_i;
   logic [1:0][3:0]  m_req_wstrb_i;
   logic [1:0]       m_req_ready_o;
   logic [1:0]       m_resp_valid_o;
   logic [31:0]      m_resp_value_o;
   logic             m_resp_err_o;
   logic             s_req_valid_o;
   logic [31:0]      s_req_addr_o;
   logic [31:0]      s_req_value_o;
   logic [3:0]       s_req_wstrb_o;
   logic             s_req_ready_i;
   logic             s_resp_valid_i;
   logic [31:0]      s_resp_value_i;
   logic             busy_o;

   bus_arbiter2 #(.TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m_req_valid_i(m_req_valid_i), .m_req_addr_i(m_req_addr_i),
      .m_req_value_i(m_req_value_i), .m_req_wstrb_i(m_req_wstrb_i),
      .m_req_ready_o(m_req_ready_o), .m_resp_valid_o(m_resp_valid_o),
      .m_resp_value_o(m_resp_value_o), .m_resp_err_o(m_resp_err_o),
      .s_req_valid_o(s_req_valid_o), .s_req_addr_o(s_req_addr_o),
      .s_req_value_o(s_req_value_o), .s_req_wstrb_o(s_req_wstrb_o),
      .s_req_ready_i(s_req_ready_i), .s_resp_valid_i(s_resp_valid_i),
      .s_resp_value_i(s_resp_value_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int passes = 0;

   // Reference model: one outstanding transaction described by its phase
   // (0 none, 1 offered to slave, 2 awaiting response), owner and age.
   int          phase;
   int          owner;
   int          last_served;
   int          waited;
   logic [31:0] lat_addr, lat_value;
   logic [3:0]  lat_wstrb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   function automatic int pick();
      if (m_req_valid_i == 2'b11) return 1 - last_served;
      return m_req_valid_i[1] ? 1 : 0;
   endfunction

   task automatic model_reset();
      phase = 0; owner = 0; last_served = 1; waited = 0;
      lat_addr = '0; lat_value = '0; lat_wstrb = '0;
   endtask

   task automatic clear_inputs();
      rst_i = 1'b0;
      m_req_valid_i = '0; m_req_addr_i = '0; m_req_value_i = '0; m_req_wstrb_i = '0;
      s_req_ready_i = 1'b0; s_resp_valid_i = 1'b0; s_resp_value_i = '0;
   endtask

   // Compare every output against the model, then advance one clock
   task automatic cycle();
      logic [1:0]  e_ready, e_rv;
      logic [31:0] e_rval;
      logic        e_err;
      int          s;
      bit          finish_txn;
      #1;
      e_ready = '0; e_rv = '0; e_rval = '0; e_err = 1'b0; s = 0;
      finish_txn = 1'b0;
      if (phase == 0 && m_req_valid_i != 2'b00) begin
         s = pick();
         e_ready[s] = 1'b1;
      end
      if (phase == 2) begin
         if (s_resp_valid_i) begin
            e_rv[owner] = 1'b1; e_rval = s_resp_value_i; finish_txn = 1'b1;
         end else if (waited == TIMEOUT) begin
            e_rv[owner] = 1'b1; e_err = 1'b1; finish_txn = 1'b1;
         end
      end
      chk("req_ready",  32'(m_req_ready_o),  32'(e_ready));
      chk("s_valid",    32'(s_req_valid_o),  32'(phase == 1));
      chk("s_addr",     s_req_addr_o,        lat_addr);
      chk("s_value",    s_req_value_o,       lat_value);
      chk("s_wstrb",    32'(s_req_wstrb_o),  32'(lat_wstrb));
      chk("resp_valid", 32'(m_resp_valid_o), 32'(e_rv));
      chk("resp_value", m_resp_value_o,      e_rval);
      chk("resp_err",   32'(m_resp_err_o),   32'(e_err));
      chk("busy",       32'(busy_o),         32'(phase != 0));
      @(posedge clk_i);
      if (rst_i) begin
         model_reset();
      end else if (phase == 0) begin
         if (m_req_valid_i != 2'b00) begin
            owner = s;
            lat_addr = m_req_addr_i[s]; lat_value = m_req_value_i[s]; lat_wstrb = m_req_wstrb_i[s];
            phase = 1;
         end
      end else if (phase == 1) begin
         if (s_req_ready_i) begin
            phase = 2; waited = 0;
         end
      end else begin
         if (finish_txn) begin
            last_served = owner; phase = 0;
         end else begin
            waited++;
         end
      end
      @(negedge clk_i);
   endtask

   initial begin
      clear_inputs();
      rst_i = 1'b1;
      model_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      cycle();                       // reset state checked while reset held
      rst_i = 1'b0;

      // Single read from a CLINT-like slave
      m_req_valid_i = 2'b01; m_req_addr_i[0] = 32'h4000; s_req_ready_i = 1'b1;
      #1 chk("rd_ready_c0", 32'(m_req_ready_o), 32'h1);
      cycle();
      m_req_valid_i = 2'b00;
      #1 chk("rd_svalid_c1", 32'(s_req_valid_o), 32'h1);
      chk("rd_saddr_c1", s_req_addr_o, 32'h4000);
      cycle();
      s_resp_valid_i = 1'b1; s_resp_value_i = 32'h1234;
      #1 chk("rd_resp_c2", 32'(m_resp_valid_o), 32'h1);
      chk("rd_value_c2", m_resp_value_o, 32'h1234);
      cycle();
      s_resp_valid_i = 1'b0;
      cycle();

      // Contention after reset: grants alternate starting with m0
      rst_i = 1'b1; cycle(); rst_i = 1'b0;
      m_req_valid_i = 2'b11; m_req_addr_i[0] = 32'h100; m_req_addr_i[1] = 32'h200;
      s_req_ready_i = 1'b1;
      for (int t = 0; t < 4; t++) begin
         #1 chk("cont_grant", 32'(m_req_ready_o), 32'(t % 2 == 0 ? 1 : 2));
         cycle();
         cycle();
         s_resp_valid_i = 1'b1; s_resp_value_i = 32'hA000_0000 + 32'(t);
         #1 chk("cont_resp", 32'(m_resp_valid_o), 32'(t % 2 == 0 ? 1 : 2));
         cycle();
         s_resp_valid_i = 1'b0;
      end
      m_req_valid_i = 2'b00;
      cycle();

      // Slave stall: request must stay stable while master inputs change
      m_req_valid_i = 2'b01; m_req_addr_i[0] = 32'h300; m_req_value_i[0] = 32'h11;
      m_req_wstrb_i[0] = 4'hF; s_req_ready_i = 1'b0;
      cycle();
      m_req_valid_i = 2'b00; m_req_addr_i[0] = 32'hDEAD_0000; m_req_value_i[0] = 32'h99;
      for (int i = 0; i < 6; i++) begin
         s_req_ready_i = (i == 5);
         #1 chk("stall_addr", s_req_addr_o, 32'h300);
         cycle();
      end
      s_resp_valid_i = 1'b1; s_resp_value_i = 32'h77;
      cycle();
      s_resp_valid_i = 1'b0;

      // Response arriving in exactly the timeout cycle is a normal response
      m_req_valid_i = 2'b10; m_req_addr_i[1] = 32'h20; s_req_ready_i = 1'b1;
      cycle();
      m_req_valid_i = 2'b00;
      cycle();
      repeat (TIMEOUT) cycle();
      s_resp_valid_i = 1'b1; s_resp_value_i = 32'hCAFE;
      #1 chk("coll_err", 32'(m_resp_err_o), 32'h0);
      chk("coll_value", m_resp_value_o, 32'hCAFE);
      cycle();
      s_resp_valid_i = 1'b0;

      // Timeout on unmapped write from m1, then a normal m0 request
      m_req_valid_i = 2'b10; m_req_addr_i[1] = 32'h10; m_req_value_i[1] = 32'hBEEF;
      m_req_wstrb_i[1] = 4'hF;
      cycle();
      m_req_valid_i = 2'b00;
      cycle();
      repeat (TIMEOUT) begin
         #1 chk("to_quiet", 32'(m_resp_valid_o), 32'h0);
         cycle();
      end
      #1 chk("to_resp", 32'(m_resp_valid_o), 32'h2);
      chk("to_err", 32'(m_resp_err_o), 32'h1);
      chk("to_value", m_resp_value_o, 32'h0);
      cycle();
      m_req_valid_i = 2'b01; m_req_addr_i[0] = 32'h400;
      #1 chk("to_next_ready", 32'(m_req_ready_o), 32'h1);
      cycle();
      m_req_valid_i = 2'b00;
      cycle();
      s_resp_valid_i = 1'b1; s_resp_value_i = 32'h55;
      cycle();
      s_resp_valid_i = 1'b0;

      // Reset in WAIT: no response, late slave response is stray, tie goes to m0
      m_req_valid_i = 2'b10; m_req_addr_i[1] = 32'h30;
      cycle();
      m_req_valid_i = 2'b00;
      cycle();
      cycle();
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0; s_resp_valid_i = 1'b1; s_resp_value_i = 32'h99;
      #1 chk("rst_no_resp", 32'(m_resp_valid_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      cycle();
      s_resp_valid_i = 1'b0; m_req_valid_i = 2'b11;
      #1 chk("rst_tie_m0", 32'(m_req_ready_o), 32'h1);
      cycle();
      m_req_valid_i = 2'b00;
      // Stray response while the request is still offered to the slave
      s_req_ready_i = 1'b0; s_resp_valid_i = 1'b1;
      #1 chk("stray_req", 32'(m_resp_valid_o), 32'h0);
      cycle();
      s_resp_valid_i = 1'b0; s_req_ready_i = 1'b1;
      cycle();
      s_resp_valid_i = 1'b1; s_resp_value_i = 32'h66;
      cycle();
      // Stray response in IDLE
      #1 chk("stray_idle", 32'(m_resp_valid_o), 32'h0);
      cycle();

      // Random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         rst_i          = ($urandom_range(0, 199) == 0);
         m_req_valid_i  = 2'($urandom_range(0, 3));
         m_req_addr_i   = {$urandom, $urandom};
         m_req_value_i  = {$urandom, $urandom};
         m_req_wstrb_i  = 8'($urandom);
         s_req_ready_i  = ($urandom_range(0, 2) != 0);
         s_resp_valid_i = ($urandom_range(0, 5) == 0);
         s_resp_value_i = $urandom;
         cycle();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
